// File: rtl/qed_dup_queue.sv
// QED duplicate queue: captures eligible original instructions, remaps their registers to
// the upper register half and replays them in order. Optional idle timeout: QED_DUP_TIMEOUT_EN.
module qed_dup_queue #(
   parameter int DEPTH   = 16,
   parameter int AW      = 4,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             reset_x,
   input  logic             ena,
   input  logic             fetch_valid,
   input  logic             stall,
   input  logic [31:0]      ifu_qed_instruction,
   input  logic             qed_drain,
   output logic             exec_dup,
   output logic [31:0]      qed_instruction,
   output logic [AW:0]      qed_occupancy,
   output logic [CNT_W-1:0] qed_orig_cnt,
   output logic [CNT_W-1:0] qed_dup_cnt,
   output logic             qed_consistent,
   output logic             o_dbg_state
);

   typedef enum logic {
      ST_ORIG = 1'b0,
      ST_DUP  = 1'b1
   } state_t;

   localparam logic [31:0]      NOP      = 32'h0000_0013;
   localparam logic [6:0]       OP_R     = 7'b0110011;
   localparam logic [6:0]       OP_IMM   = 7'b0010011;
   localparam logic [6:0]       OP_LUI   = 7'b0110111;
   localparam logic [6:0]       OP_AUIPC = 7'b0010111;
   localparam logic [AW:0]      OCC_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]      OCC_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t            r_state;
   state_t            w_state_next;
   logic [31:0]       r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_occ;
   logic [AW:0]       w_occ_next;
   logic [CNT_W-1:0]  r_orig_cnt;
   logic [CNT_W-1:0]  r_dup_cnt;

   logic              w_acc;
   logic              w_elig;
   logic              w_map_rd;
   logic              w_map_rs1;
   logic              w_map_rs2;
   logic [31:0]       w_dup_instr;
   logic              w_push;
   logic              w_pop;
   logic              w_timeout_hit;

   // fetch_valid / ~stall form a valid/ready pair: an instruction is consumed (pushed in
   // ORIG, or its duplicate popped in DUP) only on a cycle where both hold.
   assign w_acc = fetch_valid & ~stall;

   always_comb begin
      w_elig    = 1'b0;
      w_map_rd  = 1'b0;
      w_map_rs1 = 1'b0;
      w_map_rs2 = 1'b0;
      case (ifu_qed_instruction[6:0])
         OP_R: begin
            w_elig    = 1'b1;
            w_map_rd  = 1'b1;
            w_map_rs1 = 1'b1;
            w_map_rs2 = 1'b1;
         end
         OP_IMM: begin
            w_elig    = 1'b1;
            w_map_rd  = 1'b1;
            w_map_rs1 = 1'b1;
         end
         OP_LUI, OP_AUIPC: begin
            w_elig   = 1'b1;
            w_map_rd = 1'b1;
         end
         default: begin
            w_elig = 1'b0;
         end
      endcase

      // Remap xN -> xN+16 by setting bit 4 of each field; x0 must stay x0.
      w_dup_instr = ifu_qed_instruction;
      if (w_map_rd && (ifu_qed_instruction[11:7] != 5'd0)) begin
         w_dup_instr[11] = 1'b1;
      end
      if (w_map_rs1 && (ifu_qed_instruction[19:15] != 5'd0)) begin
         w_dup_instr[19] = 1'b1;
      end
      if (w_map_rs2 && (ifu_qed_instruction[24:20] != 5'd0)) begin
         w_dup_instr[24] = 1'b1;
      end
   end

   assign w_push = ena & (r_state == ST_ORIG) & w_acc & w_elig & (r_occ != OCC_FULL);
   assign w_pop  = ena & (r_state == ST_DUP) & w_acc & (r_occ != '0);

   always_comb begin
      w_occ_next = r_occ;
      if (w_push) begin
         w_occ_next = r_occ + OCC_ONE;
      end else if (w_pop) begin
         w_occ_next = r_occ - OCC_ONE;
      end
   end

`ifdef QED_DUP_TIMEOUT_EN
   localparam int            IW        = $clog2(TIMEOUT) + 1;
   localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
   localparam logic [IW-1:0] IDLE_ONE  = IW'(1);

   logic [IW-1:0] r_idle;

   always_ff @(posedge clk or negedge reset_x) begin
      if (!reset_x) begin
         r_idle <= '0;
      end else if (!ena || (r_state == ST_DUP) || (r_occ == '0)) begin
         r_idle <= '0;
      end else begin
         r_idle <= r_idle + IDLE_ONE;
      end
   end

   assign w_timeout_hit = (r_state == ST_ORIG) && (r_occ != '0) && (r_idle == IDLE_LAST);
`else
   // TIMEOUT only matters when the idle counter is built.
   assign w_timeout_hit = (TIMEOUT < 0);
`endif

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_ORIG: begin
            if ((w_occ_next == OCC_FULL) || (qed_drain && (w_occ_next != '0)) ||
                w_timeout_hit) begin
               w_state_next = ST_DUP;
            end
         end
         ST_DUP: begin
            if (w_pop && (w_occ_next == '0)) begin
               w_state_next = ST_ORIG;
            end
         end
         default: begin
            w_state_next = ST_ORIG;
         end
      endcase
      if (!ena) begin
         w_state_next = ST_ORIG;
      end
   end

   always_ff @(posedge clk or negedge reset_x) begin
      if (!reset_x) begin
         r_state <= ST_ORIG;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk or negedge reset_x) begin
      if (!reset_x) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
      end else if (!ena) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         r_occ <= w_occ_next;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_dup_instr;
      end
   end

   // Issue counters saturate at all-ones rather than wrapping.
   always_ff @(posedge clk or negedge reset_x) begin
      if (!reset_x) begin
         r_orig_cnt <= '0;
         r_dup_cnt  <= '0;
      end else if (!ena) begin
         r_orig_cnt <= '0;
         r_dup_cnt  <= '0;
      end else begin
         if (w_push && (r_orig_cnt != '1)) begin
            r_orig_cnt <= r_orig_cnt + CNT_ONE;
         end
         if (w_pop && (r_dup_cnt != '1)) begin
            r_dup_cnt <= r_dup_cnt + CNT_ONE;
         end
      end
   end

   assign exec_dup        = ena & (r_state == ST_DUP);
   assign qed_instruction = (r_occ == '0) ? NOP : r_mem[r_rd_ptr];
   assign qed_occupancy   = r_occ;
   assign qed_orig_cnt    = r_orig_cnt;
   assign qed_dup_cnt     = r_dup_cnt;
   assign qed_consistent  = ena & (r_state == ST_ORIG) & (r_occ == '0) &
                            (r_orig_cnt == r_dup_cnt);
   assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_qed_dup_queue.sv
// Self-checking bench for qed_dup_queue: directed scenarios plus randomized traffic, all
// checked every cycle against a queue-based reference model.
module tb_qed_dup_queue;

  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 64;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic             clk;
  logic             reset_x;
  logic             ena;
  logic             fetch_valid;
  logic             stall;
  logic [31:0]      ifu_qed_instruction;
  logic             qed_drain;
  logic             exec_dup;
  logic [31:0]      qed_instruction;
  logic [AW:0]      qed_occupancy;
  logic [CNT_W-1:0] qed_orig_cnt;
  logic [CNT_W-1:0] qed_dup_cnt;
  logic             qed_consistent;
  logic             dbg_state;

  qed_dup_queue #(
    .DEPTH  (DEPTH),
    .AW     (AW),
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk                (clk),
    .reset_x            (reset_x),
    .ena                (ena),
    .fetch_valid        (fetch_valid),
    .stall              (stall),
    .ifu_qed_instruction(ifu_qed_instruction),
    .qed_drain          (qed_drain),
    .exec_dup           (exec_dup),
    .qed_instruction    (qed_instruction),
    .qed_occupancy      (qed_occupancy),
    .qed_orig_cnt       (qed_orig_cnt),
    .qed_dup_cnt        (qed_dup_cnt),
    .qed_consistent     (qed_consistent),
    .o_dbg_state        (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0]      exp_q[$];
  bit               m_dup;
  logic [CNT_W-1:0] m_orig;
  logic [CNT_W-1:0] m_dupc;
  int               m_idle;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_elig(input logic [31:0] i);
    return (i[6:0] == 7'h33) || (i[6:0] == 7'h13) || (i[6:0] == 7'h37) || (i[6:0] == 7'h17);
  endfunction

  // Register fields that become xN+16 in the duplicate.
  function automatic logic [31:0] remap(input logic [31:0] i);
    logic [31:0] o;
    int nf;
    o  = i;
    nf = (i[6:0] == 7'h33) ? 3 : (i[6:0] == 7'h13) ? 2 : 1;
    if (i[11:7] != 0) o[11:7] = i[11:7] + 5'd16 * {4'd0, ~i[11]};
    if (nf >= 2 && i[19:15] != 0) o[19:15] = i[19:15] | 5'd16;
    if (nf >= 3 && i[24:20] != 0) o[24:20] = i[24:20] | 5'd16;
    return o;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_dup  = 0;
    m_orig = '0;
    m_dupc = '0;
    m_idle = 0;
  endtask

  // One clock edge of the reference behaviour, using the inputs currently applied.
  task automatic model_edge();
    bit acc;
    bit hit;
    acc = fetch_valid && !stall;
    hit = 0;
    if (!ena) begin
      model_reset();
    end else if (!m_dup) begin
`ifdef QED_DUP_TIMEOUT_EN
      hit = (exp_q.size() != 0) && (m_idle == TIMEOUT - 1);
`endif
      m_idle = (exp_q.size() != 0) ? m_idle + 1 : 0;
      if (acc && is_elig(ifu_qed_instruction) && exp_q.size() < DEPTH) begin
        exp_q.push_back(remap(ifu_qed_instruction));
        if (m_orig != '1) m_orig = m_orig + 1'b1;
      end
      if (exp_q.size() == DEPTH || (qed_drain && exp_q.size() != 0) || hit) m_dup = 1;
    end else begin
      m_idle = 0;
      if (acc && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        if (m_dupc != '1) m_dupc = m_dupc + 1'b1;
        if (exp_q.size() == 0) m_dup = 0;
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] e_ins;
    e_ins = (exp_q.size() != 0) ? exp_q[0] : NOP;
    check_eq("exec_dup", {31'd0, exec_dup}, {31'd0, ena & m_dup});
    check_eq("qed_instruction", qed_instruction, e_ins);
    check_eq("occupancy", {27'd0, qed_occupancy}, exp_q.size());
    check_eq("orig_cnt", {16'd0, qed_orig_cnt}, {16'd0, m_orig});
    check_eq("dup_cnt", {16'd0, qed_dup_cnt}, {16'd0, m_dupc});
    check_eq("consistent", {31'd0, qed_consistent},
             {31'd0, ena & !m_dup & (exp_q.size() == 0) & (m_orig == m_dupc)});
    check_eq("dbg_state", {31'd0, dbg_state}, {31'd0, m_dup});
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic e, input logic fv, input logic st,
                      input logic [31:0] ins, input logic dr);
    ena                 = e;
    fetch_valid         = fv;
    stall               = st;
    ifu_qed_instruction = ins;
    qed_drain           = dr;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 5))
      0: r[6:0] = 7'h33;
      1: r[6:0] = 7'h13;
      2: r[6:0] = 7'h37;
      3: r[6:0] = 7'h17;
      default: r[6:0] = 7'h23;
    endcase
    if ($urandom_range(0, 3) == 0) r[11:7] = 5'd0;
    if ($urandom_range(0, 3) == 0) r[19:15] = 5'd0;
    if ($urandom_range(0, 3) == 0) r[24:20] = 5'd0;
    return r;
  endfunction

  function automatic logic [31:0] rand_rtype();
    logic [31:0] r;
    r = $urandom();
    r[6:0] = 7'h33;
    return r;
  endfunction

  // ---------------- stimulus ----------------
  logic [31:0] head_save;

  initial begin
    reset_x = 1'b0;
    ena = 1'b0;
    fetch_valid = 1'b0;
    stall = 1'b0;
    ifu_qed_instruction = '0;
    qed_drain = 1'b0;
    model_reset();

    // Reset values
    repeat (2) @(negedge clk);
    check_eq("rst_exec_dup", {31'd0, exec_dup}, 32'd0);
    check_eq("rst_instr", qed_instruction, 32'h0000_0013);
    check_eq("rst_occ", {27'd0, qed_occupancy}, 32'd0);
    check_eq("rst_orig", {16'd0, qed_orig_cnt}, 32'd0);
    check_eq("rst_dup", {16'd0, qed_dup_cnt}, 32'd0);
    check_eq("rst_consistent", {31'd0, qed_consistent}, 32'd0);
    ena = 1'b1;
    #1;
    check_eq("rst_consistent_ena", {31'd0, qed_consistent}, 32'd1);
    @(negedge clk);
    reset_x = 1'b1;

    // add x1,x2,x3 then drain
    step(1, 1, 0, 32'h0031_00B3, 0);
    step(1, 0, 0, 32'h0, 1);
    check_eq("add_exec_dup", {31'd0, exec_dup}, 32'd1);
    check_eq("add_dup_instr", qed_instruction, 32'h0139_08B3);
    step(1, 1, 0, 32'h0, 0);
    check_eq("add_back_orig", {31'd0, exec_dup}, 32'd0);
    check_eq("add_counts", {qed_orig_cnt, qed_dup_cnt}, {16'd1, 16'd1});

    // addi x0,x0,0 kept as is; sw ignored; drain with empty FIFO ignored afterwards
    step(1, 1, 0, 32'h0000_0013, 0);
    check_eq("nop_occ", {27'd0, qed_occupancy}, 32'd1);
    step(1, 1, 0, 32'h0011_2023, 0);
    check_eq("sw_occ", {27'd0, qed_occupancy}, 32'd1);
    step(1, 0, 0, 32'h0, 1);
    check_eq("nop_dup_instr", qed_instruction, 32'h0000_0013);
    step(1, 1, 0, 32'h0, 0);
    step(1, 0, 0, 32'h0, 1);
    check_eq("drain_empty_ignored", {31'd0, exec_dup}, 32'd0);

    // Fill to DEPTH from fresh counters, then replay in order
    step(0, 0, 0, 32'h0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 1, 0, rand_rtype(), 0);
      if (i == DEPTH - 2) check_eq("fill_not_yet", {31'd0, exec_dup}, 32'd0);
    end
    check_eq("full_exec_dup", {31'd0, exec_dup}, 32'd1);
    check_eq("full_occ", {27'd0, qed_occupancy}, 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 1, ($urandom_range(0, 3) == 0), 32'h0, 0);
      if (stall) i--;
    end
    check_eq("replay_exec_dup", {31'd0, exec_dup}, 32'd0);
    check_eq("replay_counts", {qed_orig_cnt, qed_dup_cnt}, {16'd16, 16'd16});
    check_eq("replay_consistent", {31'd0, qed_consistent}, 32'd1);

    // Stall holds in DUP, then drop ena mid-DUP
    for (int i = 0; i < 3; i++) step(1, 1, 0, rand_rtype(), 0);
    step(1, 0, 0, 32'h0, 1);
    head_save = exp_q[0];
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 32'h0, 0);
      check_eq("stall_head", qed_instruction, head_save);
      check_eq("stall_exec_dup", {31'd0, exec_dup}, 32'd1);
      check_eq("stall_dup_cnt", {16'd0, qed_dup_cnt}, 32'd16);
    end
    step(1, 1, 0, 32'h0, 0);
    step(0, 1, 0, 32'h0, 0);
    check_eq("ena_drop_occ", {27'd0, qed_occupancy}, 32'd0);
    check_eq("ena_drop_exec", {31'd0, exec_dup}, 32'd0);
    check_eq("ena_drop_counts", {qed_orig_cnt, qed_dup_cnt}, 32'd0);

    // Idle timeout (only replays when the timeout feature is built)
    step(1, 1, 0, 32'h0031_00B3, 0);
    for (int k = 1; k <= TIMEOUT + 16; k++) begin
      step(1, 0, 0, 32'h0, 0);
`ifdef QED_DUP_TIMEOUT_EN
      if (k <= TIMEOUT)
        check_eq("timeout_exec_dup", {31'd0, exec_dup}, {31'd0, k == TIMEOUT});
`else
      check_eq("no_timeout_exec_dup", {31'd0, exec_dup}, 32'd0);
`endif
    end
    step(0, 0, 0, 32'h0, 0);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 5; i++) step(1, 1, 0, rand_rtype(), 0);
    reset_x = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    reset_x = 1'b1;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 4) == 0), rand_instr(), ($urandom_range(0, 19) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
